// File: rtl/lsu_wb_stage.sv
// rtl/lsu_wb_stage.sv - LSU->WBU pipeline register with optional two-entry skid buffer.
// Side-effect strobes are qualified with valid because the WBU does not check valid itself.
module lsu_wb_stage #(
  parameter logic [63:0] RST_PC  = 64'h0,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_in_valid,
  output logic        ls_in_ready,
  input  logic [63:0] ls_in_pc,
  input  logic [63:0] ls_in_next_pc,
  input  logic [31:0] ls_in_inst,
  input  logic        ls_in_trap,
  input  logic        ls_in_mret,
  input  logic        ls_in_sret,
  input  logic [63:0] ls_in_trap_cause,
  input  logic [63:0] ls_in_trap_tval,
  input  logic        ls_in_csr_wen,
  input  logic        ls_in_csr_ren,
  input  logic [11:0] ls_in_csr_addr,
  input  logic [4:0]  ls_in_rd,
  input  logic        ls_in_dest_wen,
  input  logic [63:0] ls_in_data,
  input  logic        WB_LS_ls_ready,
  input  logic        WB_LS_flush_flag,
  output logic        LS_WB_reg_ls_valid,
  output logic [63:0] LS_WB_reg_PC,
  output logic [63:0] LS_WB_reg_next_PC,
  output logic [31:0] LS_WB_reg_inst,
  output logic        LS_WB_reg_trap_valid,
  output logic        LS_WB_reg_mret_valid,
  output logic        LS_WB_reg_sret_valid,
  output logic [63:0] LS_WB_reg_trap_cause,
  output logic [63:0] LS_WB_reg_trap_tval,
  output logic        LS_WB_reg_csr_wen,
  output logic        LS_WB_reg_csr_ren,
  output logic [11:0] LS_WB_reg_csr_addr,
  output logic [4:0]  LS_WB_reg_rd,
  output logic        LS_WB_reg_dest_wen,
  output logic [63:0] LS_WB_reg_data,
  output logic        ls_stage_empty
);

  localparam int W = 375;
  localparam logic [W-1:0] RST_BEAT = {RST_PC, RST_PC, {(W-128){1'b0}}};

  logic [W-1:0] in_beat, main_q, skid_q;
  logic         main_valid, skid_valid, ready_q, empty_q;
  logic         acc, drain;
  logic         main_valid_n, skid_valid_n;
  logic         load_main_in, load_main_skid, load_skid;
  logic         trap_q, mret_q, sret_q, csr_wen_q, dest_wen_q;

  assign in_beat = {ls_in_pc, ls_in_next_pc, ls_in_inst, ls_in_trap, ls_in_mret, ls_in_sret,
                    ls_in_trap_cause, ls_in_trap_tval, ls_in_csr_wen, ls_in_csr_ren,
                    ls_in_csr_addr, ls_in_rd, ls_in_dest_wen, ls_in_data};

  assign ls_in_ready = SKID_EN ? ready_q : (!main_valid || WB_LS_ls_ready);
  assign acc   = ls_in_valid && ls_in_ready;
  assign drain = main_valid && WB_LS_ls_ready;

  always_comb begin
    main_valid_n   = main_valid;
    skid_valid_n   = skid_valid;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (skid_valid) begin
      if (drain) begin
        load_main_skid = 1'b1;
        skid_valid_n   = 1'b0;
      end
    end else if (main_valid) begin
      if (acc && drain) begin
        load_main_in = 1'b1;
      end else if (acc && SKID_EN) begin
        load_skid    = 1'b1;
        skid_valid_n = 1'b1;
      end else if (drain) begin
        main_valid_n = 1'b0;
      end
    end else if (acc) begin
      load_main_in = 1'b1;
      main_valid_n = 1'b1;
    end
    // Payload may still load on a flush; clearing the valids is what drops it.
    if (WB_LS_flush_flag) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      empty_q    <= 1'b1;
      main_q     <= RST_BEAT;
      skid_q     <= '0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      ready_q    <= !skid_valid_n;
      empty_q    <= !main_valid_n;
      if (load_main_in)
        main_q <= in_beat;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_beat;
    end
  end

  assign {LS_WB_reg_PC, LS_WB_reg_next_PC, LS_WB_reg_inst, trap_q, mret_q, sret_q,
          LS_WB_reg_trap_cause, LS_WB_reg_trap_tval, csr_wen_q, LS_WB_reg_csr_ren,
          LS_WB_reg_csr_addr, LS_WB_reg_rd, dest_wen_q, LS_WB_reg_data} = main_q;

  assign LS_WB_reg_ls_valid   = main_valid;
  assign LS_WB_reg_trap_valid = trap_q && main_valid;
  assign LS_WB_reg_mret_valid = mret_q && main_valid;
  assign LS_WB_reg_sret_valid = sret_q && main_valid;
  assign LS_WB_reg_csr_wen    = csr_wen_q && main_valid;
  assign LS_WB_reg_dest_wen   = dest_wen_q && main_valid && (LS_WB_reg_rd != 5'd0);
  assign ls_stage_empty       = empty_q;

endmodule

// File: tb/tb_lsu_wb_stage.sv
// tb/tb_lsu_wb_stage.sv - directed self-checking bench for lsu_wb_stage (skid and no-skid builds).
module tb_lsu_wb_stage;

  localparam logic [63:0] RPC = 64'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_pc, in_next_pc, in_cause, in_tval, in_data;
  logic [31:0] in_inst;
  logic        in_trap, in_mret, in_sret, in_csr_wen, in_csr_ren, in_dest_wen;
  logic [11:0] in_csr_addr;
  logic [4:0]  in_rd;
  logic        wb_ready, flush;

  logic        ready, valid, trap_v, mret_v, sret_v, csr_wen, csr_ren, dest_wen, empty;
  logic [63:0] pc, next_pc, cause, tval, data;
  logic [31:0] inst;
  logic [11:0] csr_addr;
  logic [4:0]  rd;

  logic        z_ready, z_valid, z_trap_v, z_mret_v, z_sret_v, z_csr_wen, z_csr_ren, z_dest_wen, z_empty;
  logic [63:0] z_pc, z_next_pc, z_cause, z_tval, z_data;
  logic [31:0] z_inst;
  logic [11:0] z_csr_addr;
  logic [4:0]  z_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_wb_stage #(.RST_PC(RPC), .SKID_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .ls_in_valid(in_valid), .ls_in_ready(ready),
    .ls_in_pc(in_pc), .ls_in_next_pc(in_next_pc), .ls_in_inst(in_inst),
    .ls_in_trap(in_trap), .ls_in_mret(in_mret), .ls_in_sret(in_sret),
    .ls_in_trap_cause(in_cause), .ls_in_trap_tval(in_tval),
    .ls_in_csr_wen(in_csr_wen), .ls_in_csr_ren(in_csr_ren), .ls_in_csr_addr(in_csr_addr),
    .ls_in_rd(in_rd), .ls_in_dest_wen(in_dest_wen), .ls_in_data(in_data),
    .WB_LS_ls_ready(wb_ready), .WB_LS_flush_flag(flush),
    .LS_WB_reg_ls_valid(valid), .LS_WB_reg_PC(pc), .LS_WB_reg_next_PC(next_pc),
    .LS_WB_reg_inst(inst), .LS_WB_reg_trap_valid(trap_v), .LS_WB_reg_mret_valid(mret_v),
    .LS_WB_reg_sret_valid(sret_v), .LS_WB_reg_trap_cause(cause), .LS_WB_reg_trap_tval(tval),
    .LS_WB_reg_csr_wen(csr_wen), .LS_WB_reg_csr_ren(csr_ren), .LS_WB_reg_csr_addr(csr_addr),
    .LS_WB_reg_rd(rd), .LS_WB_reg_dest_wen(dest_wen), .LS_WB_reg_data(data),
    .ls_stage_empty(empty)
  );

  lsu_wb_stage #(.RST_PC(RPC), .SKID_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .ls_in_valid(in_valid), .ls_in_ready(z_ready),
    .ls_in_pc(in_pc), .ls_in_next_pc(in_next_pc), .ls_in_inst(in_inst),
    .ls_in_trap(in_trap), .ls_in_mret(in_mret), .ls_in_sret(in_sret),
    .ls_in_trap_cause(in_cause), .ls_in_trap_tval(in_tval),
    .ls_in_csr_wen(in_csr_wen), .ls_in_csr_ren(in_csr_ren), .ls_in_csr_addr(in_csr_addr),
    .ls_in_rd(in_rd), .ls_in_dest_wen(in_dest_wen), .ls_in_data(in_data),
    .WB_LS_ls_ready(wb_ready), .WB_LS_flush_flag(flush),
    .LS_WB_reg_ls_valid(z_valid), .LS_WB_reg_PC(z_pc), .LS_WB_reg_next_PC(z_next_pc),
    .LS_WB_reg_inst(z_inst), .LS_WB_reg_trap_valid(z_trap_v), .LS_WB_reg_mret_valid(z_mret_v),
    .LS_WB_reg_sret_valid(z_sret_v), .LS_WB_reg_trap_cause(z_cause), .LS_WB_reg_trap_tval(z_tval),
    .LS_WB_reg_csr_wen(z_csr_wen), .LS_WB_reg_csr_ren(z_csr_ren), .LS_WB_reg_csr_addr(z_csr_addr),
    .LS_WB_reg_rd(z_rd), .LS_WB_reg_dest_wen(z_dest_wen), .LS_WB_reg_data(z_data),
    .ls_stage_empty(z_empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] p, input logic [4:0] r, input logic dw, input logic [63:0] d);
    in_valid    = 1'b1;
    in_pc       = p;
    in_next_pc  = p + 64'd4;
    in_inst     = 32'h13;
    in_rd       = r;
    in_dest_wen = dw;
    in_data     = d;
    in_trap     = 1'b0;
    in_mret     = 1'b0;
    in_sret     = 1'b0;
    in_cause    = '0;
    in_tval     = '0;
    in_csr_wen  = 1'b0;
    in_csr_ren  = 1'b0;
    in_csr_addr = '0;
  endtask

  initial begin
    rst = 1'b1; wb_ready = 1'b1; flush = 1'b0;
    beat(64'h0, 5'd0, 1'b0, 64'h0);
    in_valid = 1'b0;
    step(); step();
    check("rst_valid", valid, 0);
    check("rst_ready", ready, 1);
    check("rst_empty", empty, 1);
    check("rst_pc", pc, RPC);
    check("rst_next_pc", next_pc, RPC);
    check("rst_data", data, 0);
    rst = 1'b0;

    // single beat
    beat(64'h8000_0000, 5'd5, 1'b1, 64'h1234);
    step();
    in_valid = 1'b0;
    check("t1_valid", valid, 1);
    check("t1_pc", pc, 64'h8000_0000);
    check("t1_data", data, 64'h1234);
    check("t1_rd", rd, 5);
    check("t1_dest_wen", dest_wen, 1);
    check("t1_empty", empty, 0);
    step();
    check("t1_drained", valid, 0);
    check("t1_empty2", empty, 1);
    check("t1_dest_wen_off", dest_wen, 0);

    // backpressure with four beats
    wb_ready = 1'b0;
    beat(64'h100, 5'd1, 1'b1, 64'hA);
    step();
    check("t2_occ1_pc", pc, 64'h100);
    check("t2_occ1_ready", ready, 1);
    beat(64'h200, 5'd2, 1'b1, 64'hB);
    step();
    check("t2_occ2_ready", ready, 0);
    check("t2_occ2_pc", pc, 64'h100);
    beat(64'h300, 5'd3, 1'b1, 64'hC);
    step();
    check("t2_hold_ready", ready, 0);
    check("t2_hold_pc", pc, 64'h100);
    step();
    check("t2_hold_data", data, 64'hA);
    check("t2_hold_valid", valid, 1);
    wb_ready = 1'b1;
    step();
    check("t2_rel_b", pc, 64'h200);
    check("t2_rel_ready", ready, 1);
    step();
    check("t2_rel_c", pc, 64'h300);
    beat(64'h400, 5'd4, 1'b1, 64'hD);
    step();
    check("t2_rel_d", pc, 64'h400);
    check("t2_rel_d_data", data, 64'hD);
    in_valid = 1'b0;
    step();
    check("t2_empty", empty, 1);
    check("t2_valid", valid, 0);

    // flush at occupancy 2 with a concurrent beat
    wb_ready = 1'b0;
    beat(64'h500, 5'd3, 1'b1, 64'hE);
    in_csr_wen = 1'b1; in_trap = 1'b1; in_mret = 1'b1;
    step();
    beat(64'h600, 5'd6, 1'b1, 64'hF);
    step();
    check("t3_occ2_ready", ready, 0);
    check("t3_occ2_trap", trap_v, 1);
    beat(64'h700, 5'd7, 1'b1, 64'h77);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t3_valid", valid, 0);
    check("t3_empty", empty, 1);
    check("t3_dest_wen", dest_wen, 0);
    check("t3_csr_wen", csr_wen, 0);
    check("t3_trap", trap_v, 0);
    check("t3_mret", mret_v, 0);
    check("t3_ready", ready, 1);
    // beat accepted during a flush is dropped
    beat(64'h800, 5'd8, 1'b1, 64'h88);
    step();
    check("t3b_occ1", valid, 1);
    beat(64'h900, 5'd9, 1'b1, 64'h99);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t3b_valid", valid, 0);
    step();
    check("t3b_dropped", valid, 0);
    check("t3b_empty", empty, 1);

    // rd=0 and stale csr_wen qualification
    wb_ready = 1'b1;
    beat(64'hA00, 5'd0, 1'b1, 64'h55);
    in_csr_wen = 1'b1; in_csr_ren = 1'b1; in_csr_addr = 12'h300;
    step();
    in_valid = 1'b0;
    check("t4_valid", valid, 1);
    check("t4_rd0_dest_wen", dest_wen, 0);
    check("t4_csr_wen", csr_wen, 1);
    check("t4_csr_addr", csr_addr, 12'h300);
    step();
    check("t4_stale_csr_wen", csr_wen, 0);
    check("t4_csr_ren_unqual", csr_ren, 1);

    // trap beat
    beat(64'hB00, 5'd0, 1'b0, 64'h0);
    in_trap = 1'b1; in_cause = 64'd2; in_tval = 64'hdead;
    step();
    in_valid = 1'b0;
    check("t5_trap", trap_v, 1);
    check("t5_cause", cause, 2);
    check("t5_tval", tval, 64'hdead);
    step();
    check("t5_trap_off", trap_v, 0);

    // reset with occupancy 2
    wb_ready = 1'b0;
    beat(64'hC00, 5'd1, 1'b1, 64'h1);
    step();
    beat(64'hD00, 5'd2, 1'b1, 64'h2);
    step();
    check("t6_occ2_ready", ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("t6_valid", valid, 0);
    check("t6_pc", pc, RPC);
    check("t6_ready", ready, 1);
    check("t6_empty", empty, 1);
    check("t6_z_valid", z_valid, 0);
    check("t6_z_pc", z_pc, RPC);

    // single-entry build: one beat per cycle
    wb_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      beat(64'h10 * k, 5'd1, 1'b1, 64'(k));
      step();
      check("t7_z_valid", z_valid, 1);
      check("t7_z_pc", z_pc, 64'h10 * k);
      check("t7_z_ready", z_ready, 1);
      check("t7_pc", pc, 64'h10 * k);
    end
    wb_ready = 1'b0;
    beat(64'h50, 5'd1, 1'b1, 64'h5);
    #1;
    check("t7_z_ready_bp", z_ready, 0);
    step();
    check("t7_z_hold_pc", z_pc, 64'h40);
    in_valid = 1'b0;
    wb_ready = 1'b1;
    step();
    check("t7_z_drained", z_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
